// File: rtl/disk_manager_rw_pkg.sv
// Shared opcode, status and SD constants for the disk manager read/write block.
package disk_manager_rw_pkg;
  localparam logic [7:0] OP_NOP    = 8'd0;
  localparam logic [7:0] OP_INIT   = 8'd1;
  localparam logic [7:0] OP_BLOCK  = 8'd2;
  localparam logic [7:0] OP_OREAD  = 8'd3;
  localparam logic [7:0] OP_OWRITE = 8'd4;
  localparam logic [7:0] OP_READ   = 8'd5;
  localparam logic [7:0] OP_WBYTE  = 8'd6;
  localparam logic [7:0] OP_RBYTE  = 8'd7;
  localparam logic [7:0] OP_CLOSE  = 8'd8;

  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_ILLEGAL = 8'h01;
  localparam logic [7:0] ST_BUSY    = 8'h02;
  localparam logic [7:0] ST_ORDER   = 8'h03;
  localparam logic [7:0] ST_SHORT   = 8'h04;
  localparam logic [7:0] ST_TIMEOUT = 8'h80;

  localparam logic [5:0] SD_CMD_READ   = 6'd17;
  localparam logic [5:0] SD_CMD_WRITE  = 6'd24;
  localparam logic [5:0] SD_CMD_STREAM = 6'h3F;
  localparam logic [7:0] SD_TOKEN      = 8'hFE;

  typedef struct packed {
    logic [7:0] status;
    logic [7:0] rsvd;
    logic [7:0] data;
  } result_t;

  function automatic result_t mk_result(input logic [7:0] st, input logic [7:0] d);
    result_t r;
    r.status = st;
    r.rsvd   = 8'h00;
    r.data   = d;
    return r;
  endfunction
endpackage

// File: rtl/disk_timeout.sv
// Loadable down-counter; o_expired is high while the count sits at zero.
module disk_timeout #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_expired
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     r_cnt <= '0;
    else if (i_load)              r_cnt <= i_load_val;
    else if (i_en && r_cnt != '0) r_cnt <= r_cnt - W'(1);
  end

  assign o_expired = (r_cnt == '0);
endmodule

// File: rtl/disk_manager_rw.sv
// Host command sequencer for SD block open/read/write driving an SPI engine.
import disk_manager_rw_pkg::*;

module disk_manager_rw #(
  parameter int BLOCK_W     = 24,
  parameter int BLOCK_BYTES = 512,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] ini,
  input  logic        starti,
  output logic        busy,
  output logic        inti,
  output logic        saveresult,
  output logic [23:0] outi,
  output logic        startinit,
  input  logic        readyinit,
  output logic        startstream,
  output logic [5:0]  cmdx,
  output logic [31:0] argx,
  output logic        startx,
  output logic        init,
  output logic        start40x,
  output logic        readit,
  output logic        closex,
  input  logic [7:0]  out,
  input  logic        rdy
);
  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_W_INIT  = 4'd1;
  localparam logic [3:0] S_W_RD    = 4'd2;
  localparam logic [3:0] S_W_BYTE  = 4'd3;
  localparam logic [3:0] S_W_WCMD  = 4'd4;
  localparam logic [3:0] S_TOKEN   = 4'd5;
  localparam logic [3:0] S_W_TOKEN = 4'd6;
  localparam logic [3:0] S_OPEN_W  = 4'd7;
  localparam logic [3:0] S_W_WBYTE = 4'd8;
  localparam logic [3:0] S_W_CLOSE = 4'd9;

  localparam int CW = $clog2(BLOCK_BYTES + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [3:0]         r_state, w_nxt;
  logic [BLOCK_W-1:0] r_block;
  logic [CW-1:0]      r_count;
  result_t            r_outi;
  logic               r_inti, r_save;

  logic [7:0]  w_op, w_status, w_data;
  logic        w_idle, w_wait, w_full, w_expired, w_done, w_ord;
  logic        w_ev_int, w_ev_save, w_blk_ld, w_cnt_clr, w_cnt_inc;
  logic [31:0] w_blk32;
  logic [TW-1:0] w_tmo_val;

  assign w_op      = ini[23:16];
  assign w_idle    = (r_state == S_IDLE);
  assign w_wait    = r_state inside {S_W_INIT, S_W_RD, S_W_BYTE, S_W_WCMD,
                                     S_W_TOKEN, S_W_WBYTE, S_W_CLOSE};
  assign w_full    = (r_count == CW'(BLOCK_BYTES));
  assign w_blk32   = 32'(r_block);
  assign w_tmo_val = TW'(TIMEOUT_CYC - 1);
  assign busy      = !(w_idle || r_state == S_OPEN_W);

  // Reloaded every cycle outside a wait state, so each wait starts a fresh window.
  disk_timeout #(.W(TW)) u_tmo (
    .clk        (clk),
    .rst        (rst),
    .i_load     (!w_wait),
    .i_load_val (w_tmo_val),
    .i_en       (w_wait),
    .o_expired  (w_expired)
  );

  always_comb begin
    w_nxt = r_state;
    w_ev_int = 1'b0; w_ev_save = 1'b0; w_status = ST_OK; w_data = 8'h00;
    w_blk_ld = 1'b0; w_cnt_clr = 1'b0; w_cnt_inc = 1'b0; w_done = 1'b0; w_ord = 1'b0;
    startinit = 1'b0; init = 1'b0; startstream = 1'b0; startx = 1'b0;
    start40x = 1'b0; readit = 1'b0; closex = 1'b0;
    cmdx = '0; argx = '0;
    if (starti && busy) begin
      w_ev_save = 1'b1; w_status = ST_BUSY;
    end else if (starti) begin
      case (w_op)
        OP_NOP:    begin end
        OP_BLOCK:  w_blk_ld = 1'b1;
        OP_INIT:   if (w_idle) begin startinit = 1'b1; init = 1'b1; w_nxt = S_W_INIT; end
                   else w_ord = 1'b1;
        OP_OREAD:  if (w_idle) begin cmdx = SD_CMD_READ; argx = w_blk32; start40x = 1'b1; w_nxt = S_W_RD; end
                   else w_ord = 1'b1;
        OP_OWRITE: if (w_idle) begin cmdx = SD_CMD_WRITE; argx = w_blk32; start40x = 1'b1; w_nxt = S_W_WCMD; end
                   else w_ord = 1'b1;
        OP_READ:   if (w_idle) begin cmdx = SD_CMD_STREAM; argx = 32'hFFFF_FFFF; startx = 1'b1; readit = 1'b1; w_nxt = S_W_RD; end
                   else w_ord = 1'b1;
        OP_WBYTE:  if (!w_idle && !w_full) begin argx = {24'h0, ini[7:0]}; startx = 1'b1; start40x = 1'b1; w_nxt = S_W_WBYTE; end
                   else w_ord = 1'b1;
        OP_RBYTE:  if (w_idle) begin startstream = 1'b1; w_nxt = S_W_BYTE; end
                   else w_ord = 1'b1;
        OP_CLOSE:  if (!w_idle) begin closex = 1'b1; w_nxt = S_W_CLOSE; end
                   else w_ord = 1'b1;
        default:   begin w_ev_save = 1'b1; w_status = ST_ILLEGAL; end
      endcase
      if (w_ord) begin w_ev_save = 1'b1; w_status = ST_ORDER; end
    end
    // Completion events take priority over a BUSY report landing in the same cycle.
    case (r_state)
      S_TOKEN:   begin argx = {24'h0, SD_TOKEN}; startx = 1'b1; start40x = 1'b1; w_nxt = S_W_TOKEN; end
      S_W_INIT:  if (readyinit) begin w_done = 1'b1; w_nxt = S_IDLE; w_ev_int = 1'b1; w_ev_save = 1'b1; w_status = ST_OK; end
      S_W_RD:    if (rdy) begin w_done = 1'b1; w_nxt = S_IDLE; w_ev_int = 1'b1; end
      S_W_BYTE:  if (rdy) begin w_done = 1'b1; w_nxt = S_IDLE; w_ev_save = 1'b1; w_status = ST_OK; w_data = out; end
      S_W_WCMD:  if (rdy) begin w_done = 1'b1; w_nxt = S_TOKEN; end
      S_W_TOKEN: if (rdy) begin w_done = 1'b1; w_nxt = S_OPEN_W; w_cnt_clr = 1'b1; w_ev_save = 1'b1; w_status = ST_OK; end
      S_W_WBYTE: if (rdy) begin w_done = 1'b1; w_nxt = S_OPEN_W; w_cnt_inc = 1'b1; w_ev_int = 1'b1; end
      S_W_CLOSE: if (rdy) begin
                   w_done = 1'b1; w_nxt = S_IDLE; w_ev_int = 1'b1; w_ev_save = 1'b1;
                   w_status = w_full ? ST_OK : ST_SHORT;
                 end
      default:   begin end
    endcase
    if (w_wait && !w_done && w_expired) begin
      w_nxt = S_IDLE; w_ev_int = 1'b0; w_ev_save = 1'b1; w_status = ST_TIMEOUT; w_data = 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_block <= '0;
      r_count <= '0;
      r_outi  <= '0;
      r_inti  <= 1'b0;
      r_save  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_inti  <= w_ev_int;
      r_save  <= w_ev_save;
      if (w_ev_save) r_outi  <= mk_result(w_status, w_data);
      if (w_blk_ld)  r_block <= BLOCK_W'(ini[15:0]);
      if (w_cnt_clr)      r_count <= '0;
      else if (w_cnt_inc) r_count <= r_count + CW'(1);
    end
  end

  assign inti       = r_inti;
  assign saveresult = r_save;
  assign outi       = r_outi;
endmodule

// File: tb/tb_disk_manager_rw.sv
// Randomized self-checking bench with a transaction-level model of the host protocol.
module tb_disk_manager_rw;
  localparam int TMO = 100;
  localparam int BB  = 512;
  localparam logic [7:0] NOP = 8'd0, INIT = 8'd1, BLOCK = 8'd2, OREAD = 8'd3, OWRITE = 8'd4,
                         READ = 8'd5, WBYTE = 8'd6, RBYTE = 8'd7, CLOSE = 8'd8;

  logic clk = 1'b0, rst = 1'b0;
  logic [23:0] ini;
  logic starti, readyinit, rdy;
  logic [7:0] out;
  logic busy, inti, saveresult, startinit, startstream, startx, init, start40x, readit, closex;
  logic [23:0] outi;
  logic [5:0]  cmdx;
  logic [31:0] argx;
  logic [6:0]  stb;

  assign stb = {startinit, init, startstream, startx, start40x, readit, closex};

  disk_manager_rw #(.BLOCK_W(24), .BLOCK_BYTES(BB), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .ini(ini), .starti(starti), .busy(busy), .inti(inti),
    .saveresult(saveresult), .outi(outi), .startinit(startinit), .readyinit(readyinit),
    .startstream(startstream), .cmdx(cmdx), .argx(argx), .startx(startx), .init(init),
    .start40x(start40x), .readit(readit), .closex(closex), .out(out), .rdy(rdy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  bit m_open;
  int m_cnt;
  logic [15:0] m_block;
  logic [23:0] m_outi;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_rdy(input bit use_init, input logic [7:0] b);
    @(negedge clk);
    if (use_init) readyinit = 1'b1; else rdy = 1'b1;
    out = b;
    @(negedge clk);
    rdy = 1'b0; readyinit = 1'b0;
  endtask

  task automatic do_cmd(input logic [7:0] op, input logic [15:0] pl, input int lat, input logic [7:0] db);
    logic [6:0] e_stb; logic [5:0] e_cmd; logic [31:0] e_arg; logic [7:0] e_st, e_dat;
    bit eng, e_int, e_sav, tok, ord, chk_c, chk_a, early;
    e_stb = '0; e_cmd = '0; e_arg = '0; e_st = 8'h00; e_dat = 8'h00;
    eng = 0; e_int = 0; e_sav = 0; tok = 0; ord = 0; chk_c = 0; chk_a = 0; early = 0;
    case (op)
      NOP, BLOCK: begin end
      INIT:   if (!m_open) begin e_stb = 7'b1100000; eng = 1; e_int = 1; e_sav = 1; end else ord = 1;
      OREAD:  if (!m_open) begin e_stb = 7'b0000100; e_cmd = 6'd17; e_arg = {16'h0, m_block};
                eng = 1; e_int = 1; chk_c = 1; chk_a = 1; end else ord = 1;
      OWRITE: if (!m_open) begin e_stb = 7'b0000100; e_cmd = 6'd24; e_arg = {16'h0, m_block};
                eng = 1; tok = 1; e_sav = 1; chk_c = 1; chk_a = 1; end else ord = 1;
      READ:   if (!m_open) begin e_stb = 7'b0001010; e_cmd = 6'h3F; e_arg = 32'hFFFF_FFFF;
                eng = 1; e_int = 1; chk_c = 1; chk_a = 1; end else ord = 1;
      WBYTE:  if (m_open && m_cnt < BB) begin e_stb = 7'b0001100; e_arg = {24'h0, pl[7:0]};
                eng = 1; e_int = 1; chk_a = 1; end else ord = 1;
      RBYTE:  if (!m_open) begin e_stb = 7'b0010000; eng = 1; e_sav = 1; e_dat = db; end else ord = 1;
      CLOSE:  if (m_open) begin e_stb = 7'b0000001; eng = 1; e_int = 1; e_sav = 1;
                e_st = (m_cnt == BB) ? 8'h00 : 8'h04; end else ord = 1;
      default: begin e_sav = 1; e_st = 8'h01; end
    endcase
    if (ord) begin e_sav = 1; e_st = 8'h03; end

    @(negedge clk);
    ini = {op, pl}; starti = 1'b1;
    #1;
    chk($sformatf("strobes op%0h", op), stb, e_stb);
    if (chk_c) chk($sformatf("cmdx op%0h", op), cmdx, e_cmd);
    if (chk_a) chk($sformatf("argx op%0h", op), argx, e_arg);
    @(negedge clk);
    starti = 1'b0;
    if (op == BLOCK) m_block = pl;
    if (eng) begin
      chk($sformatf("busy_run op%0h", op), busy, 1'b1);
      repeat (lat) begin @(negedge clk); early |= inti | saveresult; end
      pulse_rdy(op == INIT, db);
      if (tok) begin
        chk("token_strobes", stb, 7'b0001100);
        chk("token_argx", argx, 32'h0000_00FE);
        early |= inti | saveresult;
        repeat (lat) begin @(negedge clk); early |= inti | saveresult; end
        pulse_rdy(1'b0, 8'($urandom));
      end
      chk($sformatf("early_pulse op%0h", op), early, 1'b0);
      if (op == OWRITE) begin m_open = 1; m_cnt = 0; end
      if (op == WBYTE) m_cnt++;
      if (op == CLOSE) m_open = 0;
    end
    if (e_sav) m_outi = {e_st, 8'h00, e_dat};
    chk($sformatf("inti op%0h", op), inti, e_int);
    chk($sformatf("save op%0h", op), saveresult, e_sav);
    chk($sformatf("outi op%0h", op), outi, m_outi);
    chk($sformatf("busy_end op%0h", op), busy, 1'b0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    ini = '0; starti = 0; readyinit = 0; rdy = 0; out = '0;
    m_open = 0; m_cnt = 0; m_block = '0; m_outi = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {busy, inti, saveresult, outi, stb}, '0);
    chk("rst_bus", {cmdx, argx}, '0);
    rst = 1'b1;

    do_cmd(BLOCK, 16'h0123, 0, 8'h00);
    do_cmd(OREAD, 16'h0000, 10, 8'h00);
    do_cmd(RBYTE, 16'h0000, 3, 8'hA5);
    do_cmd(8'h3C, 16'h1234, 0, 8'h00);
    do_cmd(WBYTE, 16'h0055, 0, 8'h00);
    do_cmd(CLOSE, 16'h0000, 0, 8'h00);
    do_cmd(INIT, 16'h0000, 5, 8'h00);
    do_cmd(READ, 16'h0000, 2, 8'h00);

    // Second command while an OREAD is outstanding.
    @(negedge clk); ini = {OREAD, 16'h0}; starti = 1'b1;
    @(negedge clk); ini = {READ, 16'h0};
    #1 chk("busy_drop_strobes", stb, 7'b0);
    @(negedge clk); starti = 1'b0;
    m_outi = 24'h020000;
    chk("busy_save", saveresult, 1'b1);
    chk("busy_outi", outi, m_outi);
    chk("busy_still", busy, 1'b1);
    repeat (4) @(negedge clk);
    pulse_rdy(1'b0, 8'h11);
    chk("busy_orig_inti", inti, 1'b1);
    chk("busy_orig_save", saveresult, 1'b0);
    chk("busy_orig_outi", outi, m_outi);

    // Withheld rdy: timeout reported TMO cycles after acceptance.
    @(negedge clk); ini = {OREAD, 16'h0}; starti = 1'b1;
    @(negedge clk); starti = 1'b0;
    k = 0;
    while (!saveresult && k < 300) begin @(negedge clk); k++; end
    m_outi = 24'h800000;
    chk("tmo_cycles", k, TMO);
    chk("tmo_outi", outi, m_outi);
    chk("tmo_no_inti", inti, 1'b0);
    chk("tmo_busy", busy, 1'b0);

    // Full block, overflow write, clean close.
    do_cmd(BLOCK, 16'hBEEF, 0, 8'h00);
    do_cmd(OWRITE, 16'h0000, 2, 8'h00);
    for (int i = 0; i < BB; i++) do_cmd(WBYTE, 16'($urandom), $urandom_range(0, 1), 8'h00);
    do_cmd(WBYTE, 16'h00AA, 0, 8'h00);
    do_cmd(CLOSE, 16'h0000, 1, 8'h00);

    for (int i = 0; i < 80; i++) begin
      int r;
      logic [7:0] op;
      r = $urandom_range(0, 11);
      if (m_open) op = (r < 6) ? WBYTE : (r < 8) ? CLOSE : (r < 10) ? BLOCK : (r < 11) ? NOP : 8'($urandom_range(9, 255));
      else        op = (r < 9) ? 8'(r) : (r < 11) ? OWRITE : 8'($urandom_range(9, 255));
      do_cmd(op, 16'($urandom), $urandom_range(0, 6), 8'($urandom));
    end
    if (m_open) do_cmd(CLOSE, 16'h0, 0, 8'h00);

    // Reset while an OWRITE is waiting for the engine.
    do_cmd(BLOCK, 16'h0042, 0, 8'h00);
    @(negedge clk); ini = {OWRITE, 16'h0}; starti = 1'b1;
    @(negedge clk); starti = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_ctl", {busy, inti, saveresult, outi, stb}, '0);
    chk("midrst_bus", {cmdx, argx}, '0);
    @(negedge clk); rst = 1'b1;
    m_open = 0; m_cnt = 0; m_block = '0; m_outi = '0;
    @(negedge clk);
    chk("postrst_quiet", {inti, saveresult, busy}, '0);
    do_cmd(INIT, 16'h0000, 4, 8'h00);
    do_cmd(OREAD, 16'h0000, 1, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/disk_manager_rw.md
DISK_MANAGER_RW -- requirements
Module: disk_manager_rw

Interface
REQ-001 Parameter BLOCK_W, default 24, width of the SD block address latched by BLOCK.
REQ-002 Parameter BLOCK_BYTES, default 512, bytes per written block.
REQ-003 Parameter TIMEOUT_CYC, default 65535, maximum cycles waiting for rdy/readyinit.
REQ-004 clk  in  1  system clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 ini  in  24  host command: [23:16] opcode, [15:0] payload.
REQ-007 starti  in  1  one-cycle host command strobe.
REQ-008 busy  out  1  high while an operation is outstanding.
REQ-009 inti  out  1  one-cycle completion pulse.
REQ-010 saveresult  out  1  one-cycle pulse; outi valid this cycle.
REQ-011 outi  out  24  result word {status[7:0], 8'h00, data[7:0]}.
REQ-012 startinit / readyinit  out / in  1  card-init request pulse / init-done pulse.
REQ-013 startstream  out  1  one-cycle read-byte request to SPI engine.
REQ-014 cmdx, argx  out  6, 32  SD command index and argument, valid with start strobes.
REQ-015 startx, init, start40x, readit, closex  out  1  one-cycle SPI engine strobes.
REQ-016 out, rdy  in  8, 1  SPI engine data byte and one-cycle done pulse.

Function
REQ-017 Opcodes: 0 NOP, 1 INIT, 2 BLOCK, 3 OREAD, 4 OWRITE, 5 READ, 6 WRITEBYTE, 7 READBYTE, 8 CLOSE; others -> status 8'h01 (ILLEGAL), saveresult pulse next cycle.
REQ-018 FSM states: IDLE, W_INIT, W_RD, W_BYTE, W_WCMD, TOKEN, W_TOKEN, OPEN_W, W_WBYTE, W_CLOSE.
REQ-019 starti while busy=1: command dropped, status 8'h02 (BUSY) reported via saveresult next cycle, FSM unaffected.
REQ-020 BLOCK: n_block <= zero-extended ini[15:0] (BLOCK_W>16 upper bits cleared); no strobe, no pulse, legal in IDLE and OPEN_W.
REQ-021 INIT (IDLE only): startinit pulse same cycle -> W_INIT; readyinit -> inti, status 0, IDLE.
REQ-022 OREAD: cmdx=17, argx=block zero-extended to 32, start40x pulse -> W_RD; rdy -> inti, IDLE.
REQ-023 READ: cmdx=6'h3F, argx=32'hFFFFFFFF, startx+readit pulse -> W_RD.
REQ-024 READBYTE: startstream pulse -> W_BYTE; rdy -> saveresult with outi data=out, status 0.
REQ-025 OWRITE: cmdx=24, argx=block, start40x -> W_WCMD; rdy -> TOKEN; TOKEN drives argx=8'hFE, startx+start40x for one cycle -> W_TOKEN; rdy -> OPEN_W, byte count cleared, saveresult status 0.
REQ-026 WRITEBYTE legal only in OPEN_W: argx={24'h0,ini[7:0]}, startx+start40x -> W_WBYTE; rdy -> count+1, OPEN_W, inti.
REQ-027 WRITEBYTE with count==BLOCK_BYTES, or outside OPEN_W: status 8'h03 (ORDER), no strobe.
REQ-028 CLOSE from OPEN_W: closex pulse -> W_CLOSE; rdy -> inti, IDLE, status 0 if count==BLOCK_BYTES else 8'h04 (SHORT).
REQ-029 busy=1 in every state except IDLE and OPEN_W.
REQ-030 Every W_* state counts cycles; reaching TIMEOUT_CYC -> IDLE, saveresult status 8'h80, no inti.
REQ-031 rdy/readyinit arriving in IDLE or OPEN_W is ignored.
REQ-032 Strobes are combinational decodes of the accepting cycle; outi is registered and holds last value.

Reset
REQ-033 rst low: FSM=IDLE, block=0, count=0, timer=0, outi=0, all strobes and pulses 0, busy=0; mid-operation abort produces no pulse.

Structure
REQ-034 Shared package holds opcodes, status codes, SD command constants (17, 24, 8'hFE).
REQ-035 One sub-module, disk_timeout, a loadable down-counter with expire flag.

Verification
REQ-036 Reset low mid-OWRITE -> all outputs 0, busy=0, next INIT accepted.
REQ-037 BLOCK 0x0123, OREAD, rdy after 10 cycles -> cmdx=17, argx=0x00000123, inti one cycle after rdy.
REQ-038 READBYTE, rdy with out=0xA5 -> saveresult, outi=24'h0000A5.
REQ-039 OWRITE, token, 512 WRITEBYTEs, CLOSE -> status 0; 513th WRITEBYTE -> status 8'h03.
REQ-040 OREAD with rdy withheld, TIMEOUT_CYC=100 -> status 8'h80 at cycle 100, busy drops.
REQ-041 starti during W_RD -> status 8'h02, original OREAD completes normally.
